jtag_1149_d10_mstr_tx_instr_sequencer: RTL

Master-side transmit instruction sequencer for the IEEE 1149.10 PEDDA master, directly downstream of the Rx controller's status outputs.
- Accepts one instruction at a time from the host instruction queue and launches it to the Tx packet framer (`send_pkt`/`send_pkt_type`).
- Holds the instruction until the Rx side reports the response outcome.
- Re-sends on `instr_retry`, pauses on `suspend_xmission`, and aborts on unrecoverable error or response timeout.

---
 rtl/jtag_1149_d10_mstr_pkg.sv | 32 +++
 rtl/jtag_1149_d10_mstr_tx_instr_sequencer_if.sv | 42 ++++
 rtl/jtag_1149_d10_mstr_sat_cntr.sv | 24 ++
 rtl/jtag_1149_d10_mstr_tx_instr_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/jtag_1149_d10_mstr_pkg.sv
// Shared definitions for the 1149.10 PEDDA master: sequencer state encoding,
// packet-type byte constants (shared with the Rx packet detector) and the
// default status-counter width. No ports; imported by the master-side blocks.
package jtag_1149_d10_mstr_pkg;

   localparam int STAT_WIDTH_DFLT = 16;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HOLD      = 3'd1;
   localparam logic [2:0] ST_SEND      = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_WAIT_RSP  = 3'd4;
   localparam logic [2:0] ST_ABORT     = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_HOLD      = ST_HOLD,
      S_SEND      = ST_SEND,
      S_WAIT_DONE = ST_WAIT_DONE,
      S_WAIT_RSP  = ST_WAIT_RSP,
      S_ABORT     = ST_ABORT
   } seq_state_t;

   // Packet-type bytes carried in the PEDDA packet header
   localparam logic [7:0] PKT_TYPE_RESET    = 8'h00;
   localparam logic [7:0] PKT_TYPE_CONFIG   = 8'h01;
   localparam logic [7:0] PKT_TYPE_SCAN     = 8'h02;
   localparam logic [7:0] PKT_TYPE_RAW_SCAN = 8'h04;
   localparam logic [7:0] PKT_TYPE_RESPONSE = 8'h80;

endpackage

// File: rtl/jtag_1149_d10_mstr_tx_instr_sequencer_if.sv
// Handshake bundle between host queue, Tx framer, Rx controller and the
// instruction sequencer. master = sequencer side, slave = its environment.
// Signals: host request (vld/type/len/rdy), framer launch, Rx status, stats.
interface jtag_1149_d10_mstr_tx_instr_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int STAT_WIDTH = 16
);
   logic                  instr_req_vld;
   logic [DATA_WIDTH-1:0] instr_req_type;
   logic [LEN_WIDTH-1:0]  instr_req_len;
   logic                  instr_req_rdy;
   logic                  send_pkt;
   logic [DATA_WIDTH-1:0] send_pkt_type;
   logic [LEN_WIDTH-1:0]  send_pkt_len;
   logic                  framer_done;
   logic                  rd_nxt_instr;
   logic                  instr_retry;
   logic                  suspend_xmission;
   logic                  unrecoverable_error;
   logic                  scan_rsp_time_out;
   logic                  instr_done;
   logic                  instr_abort;
   logic [STAT_WIDTH-1:0] retry_total;
   logic [STAT_WIDTH-1:0] instr_total;

   modport master (
      input  instr_req_vld, instr_req_type, instr_req_len,
      input  framer_done, rd_nxt_instr, instr_retry, suspend_xmission,
      input  unrecoverable_error, scan_rsp_time_out,
      output instr_req_rdy, send_pkt, send_pkt_type, send_pkt_len,
      output instr_done, instr_abort, retry_total, instr_total
   );

   modport slave (
      output instr_req_vld, instr_req_type, instr_req_len,
      output framer_done, rd_nxt_instr, instr_retry, suspend_xmission,
      output unrecoverable_error, scan_rsp_time_out,
      input  instr_req_rdy, send_pkt, send_pkt_type, send_pkt_len,
      input  instr_done, instr_abort, retry_total, instr_total
   );
endinterface

// File: rtl/jtag_1149_d10_mstr_sat_cntr.sv
// Event counter: increments on inc; sat_en=1 holds at all-ones, sat_en=0 wraps.
// Latency: count visible the cycle after inc. No backpressure.
// Ports: clk, rst_n, inc, sat_en in; cnt out (resets to 0).
module jtag_1149_d10_mstr_sat_cntr
   import jtag_1149_d10_mstr_pkg::*;
#(
   parameter int WIDTH = STAT_WIDTH_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             sat_en,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && !(sat_en && (&cnt))) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/jtag_1149_d10_mstr_tx_instr_sequencer.sv
// Master Tx instruction sequencer: holds one host instruction, launches it to
// the framer, resends on retry, waits out XOFF in HOLD, aborts on error/timeout.
// Latency: accept N -> send_pkt N+2; rdy only in IDLE (one instruction in flight).
// Ports: clk, rst_n, bus (master modport: host req, framer launch, Rx status, stats).
module jtag_1149_d10_mstr_tx_instr_sequencer
   import jtag_1149_d10_mstr_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8,
   parameter int STAT_WIDTH = STAT_WIDTH_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   jtag_1149_d10_mstr_tx_instr_sequencer_if.master bus
);

   seq_state_t state, next_state;
   logic       retry_pend, retry_pend_nxt;
   logic       capture;
   logic       retry_inc;
   logic       done_nxt;
   logic       fatal_evt;

   assign fatal_evt = bus.unrecoverable_error | bus.scan_rsp_time_out;

   always_comb begin
      next_state     = state;
      retry_pend_nxt = retry_pend;
      capture        = 1'b0;
      retry_inc      = 1'b0;
      done_nxt       = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.instr_req_vld) begin
               capture        = 1'b1;
               retry_pend_nxt = 1'b0;
               next_state     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!bus.suspend_xmission) next_state = S_SEND;
         end
         S_SEND: next_state = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (fatal_evt) begin
               next_state = S_ABORT;
            end else begin
               if (bus.instr_retry) retry_pend_nxt = 1'b1;
               if (bus.framer_done) begin
                  // A retry arriving in the same cycle as framer_done still counts
                  if (retry_pend || bus.instr_retry) begin
                     retry_inc      = 1'b1;
                     retry_pend_nxt = 1'b0;
                     next_state     = S_HOLD;
                  end else begin
                     next_state = S_WAIT_RSP;
                  end
               end
            end
         end
         S_WAIT_RSP: begin
            if (fatal_evt) begin
               next_state = S_ABORT;
            end else if (bus.instr_retry) begin
               retry_inc  = 1'b1;
               next_state = S_HOLD;
            end else if (bus.rd_nxt_instr) begin
               done_nxt   = 1'b1;
               next_state = S_IDLE;
            end
         end
         S_ABORT: next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Strobe outputs are registered from next_state so they line up with the
   // state they describe and cannot glitch when reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= S_IDLE;
         retry_pend        <= 1'b0;
         bus.instr_req_rdy <= 1'b1;
         bus.send_pkt      <= 1'b0;
         bus.instr_done    <= 1'b0;
         bus.instr_abort   <= 1'b0;
         bus.send_pkt_type <= '0;
         bus.send_pkt_len  <= '0;
      end else begin
         state             <= next_state;
         retry_pend        <= retry_pend_nxt;
         bus.instr_req_rdy <= (next_state == S_IDLE);
         bus.send_pkt      <= (next_state == S_SEND);
         bus.instr_done    <= done_nxt;
         bus.instr_abort   <= (next_state == S_ABORT);
         if (capture) begin
            bus.send_pkt_type <= bus.instr_req_type;
            bus.send_pkt_len  <= bus.instr_req_len;
         end
      end
   end

   jtag_1149_d10_mstr_sat_cntr #(.WIDTH(STAT_WIDTH)) u_retry_cntr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (retry_inc),
      .sat_en (1'b1),
      .cnt    (bus.retry_total)
   );

   jtag_1149_d10_mstr_sat_cntr #(.WIDTH(STAT_WIDTH)) u_instr_cntr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (done_nxt),
      .sat_en (1'b0),
      .cnt    (bus.instr_total)
   );

endmodule
